// File: rtl/indicator_scan_if.sv
// indicator_scan_if: display-driver bus between control logic and the scan driver.
//   value    : DIGITS hex nibbles; value[3:0] is digit 0, the rightmost digit
//   dp_in    : per-digit decimal point request
//   load     : capture value/dp_in this cycle
//   lz_en    : leading-zero suppression enable
//   enable   : display enable
//   segments : {dp, g..a} in the driver's configured polarity
//   anodes   : one-hot digit select in the driver's configured polarity
//   frame    : one-cycle pulse at the end of each full scan
// The master modport is the controller side; the slave modport is the driver side.
interface indicator_scan_if #(
  parameter int unsigned DIGITS = 4
) ();
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   dp_in;
  logic                load;
  logic                lz_en;
  logic                enable;
  logic [7:0]          segments;
  logic [DIGITS-1:0]   anodes;
  logic                frame;

  modport master (
    output value, dp_in, load, lz_en, enable,
    input  segments, anodes, frame
  );

  modport slave (
    input  value, dp_in, load, lz_en, enable,
    output segments, anodes, frame
  );
endinterface

// File: rtl/indicator_scan.sv
// indicator_scan: multiplexed DIGITS-digit hex 7-segment display driver.
//   clk     : system clock
//   rst     : asynchronous active-high reset
//   disp_io : indicator_scan_if slave (value/dp_in/load/lz_en/enable in,
//             segments/anodes/frame out, all outputs registered)
// Each digit slot lasts PRESCALE clocks; the first GUARD clocks of a slot keep
// every anode and segment off to avoid ghosting. Loaded data is held in a
// pending buffer and only moved to the displayed buffer at a frame wrap, so a
// single scan never mixes two values.
module indicator_scan #(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned PRESCALE       = 50000,
  parameter int unsigned GUARD          = 2,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input logic             clk,
  input logic             rst,
  indicator_scan_if.slave disp_io
);

  localparam int unsigned CntW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [7:0]        SegOff = {8{SEG_ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] AnOff  = {DIGITS{AN_ACTIVE_LOW}};

  // Active-low glyphs with the dp bit (bit 7) unlit.
  function automatic logic [7:0] glyph(input logic [3:0] nib);
    logic [7:0] g;
    case (nib)
      4'h0:    g = 8'hC0;
      4'h1:    g = 8'hF9;
      4'h2:    g = 8'hA4;
      4'h3:    g = 8'hB0;
      4'h4:    g = 8'h99;
      4'h5:    g = 8'h92;
      4'h6:    g = 8'h82;
      4'h7:    g = 8'hF8;
      4'h8:    g = 8'h80;
      4'h9:    g = 8'h90;
      4'hA:    g = 8'h88;
      4'hB:    g = 8'h83;
      4'hC:    g = 8'hC6;
      4'hD:    g = 8'hA1;
      4'hE:    g = 8'h86;
      default: g = 8'h8E;
    endcase
    return g;
  endfunction

  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [4*DIGITS-1:0] pend_val_q, pend_val_d;
  logic [DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                pend_flag_q, pend_flag_d;
  logic [4*DIGITS-1:0] act_val_q, act_val_d;
  logic [DIGITS-1:0]   act_dp_q, act_dp_d;
  logic [7:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                frame_q, frame_d;

  logic tick, last_digit, wrap;

  assign tick       = (cnt_q == CntW'(PRESCALE - 1));
  assign last_digit = (idx_q == IdxW'(DIGITS - 1));
  assign wrap       = disp_io.enable && tick && last_digit;

  // Slot timing: prescaler and digit index.
  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    idx_d = idx_q;
    if (!disp_io.enable) begin
      cnt_d = '0;
      idx_d = '0;
    end else if (tick) begin
      cnt_d = '0;
      idx_d = last_digit ? '0 : idx_q + IdxW'(1);
    end
  end

  // Double-buffered display data; the displayed copy only changes at a wrap.
  always_comb begin
    pend_val_d  = pend_val_q;
    pend_dp_d   = pend_dp_q;
    pend_flag_d = pend_flag_q;
    act_val_d   = act_val_q;
    act_dp_d    = act_dp_q;
    if (wrap) begin
      if (disp_io.load) begin
        act_val_d   = disp_io.value;
        act_dp_d    = disp_io.dp_in;
        pend_flag_d = 1'b0;
      end else if (pend_flag_q) begin
        act_val_d   = pend_val_q;
        act_dp_d    = pend_dp_q;
        pend_flag_d = 1'b0;
      end
    end else if (disp_io.load) begin
      pend_val_d  = disp_io.value;
      pend_dp_d   = disp_io.dp_in;
      pend_flag_d = 1'b1;
    end
  end

  // Output decode for the current slot.
  always_comb begin
    logic [3:0]        cur_nib;
    logic              cur_dp;
    logic              cur_lead;
    logic              zero_run;
    logic              blank;
    logic              lit;
    logic [7:0]        seg_raw;
    logic [DIGITS-1:0] an_raw;
    cur_nib  = '0;
    cur_dp   = 1'b0;
    cur_lead = 1'b0;
    zero_run = 1'b1;
    an_raw   = '0;
    // Walk from the most significant digit down; zero_run stays set while all
    // nibbles from the top down to digit k are zero.
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run & (act_val_q[4*k +: 4] == 4'h0);
      if (IdxW'(k) == idx_q) begin
        cur_nib   = act_val_q[4*k +: 4];
        cur_dp    = act_dp_q[k];
        cur_lead  = zero_run;
        an_raw[k] = 1'b1;
      end
    end
    blank   = disp_io.lz_en && (idx_q != '0) && cur_lead;
    seg_raw = blank ? 8'hFF : glyph(cur_nib);
    if (cur_dp) seg_raw[7] = 1'b0;
    lit     = disp_io.enable && (cnt_q >= CntW'(GUARD));
    seg_d   = lit ? (seg_raw ^ {8{~SEG_ACTIVE_LOW}}) : SegOff;
    an_d    = lit ? (an_raw ^ {DIGITS{AN_ACTIVE_LOW}}) : AnOff;
    frame_d = wrap;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      pend_val_q  <= '0;
      pend_dp_q   <= '0;
      pend_flag_q <= 1'b0;
      act_val_q   <= '0;
      act_dp_q    <= '0;
      seg_q       <= SegOff;
      an_q        <= AnOff;
      frame_q     <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      pend_val_q  <= pend_val_d;
      pend_dp_q   <= pend_dp_d;
      pend_flag_q <= pend_flag_d;
      act_val_q   <= act_val_d;
      act_dp_q    <= act_dp_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
      frame_q     <= frame_d;
    end
  end

  assign disp_io.segments = seg_q;
  assign disp_io.anodes   = an_q;
  assign disp_io.frame    = frame_q;

endmodule

// File: tb/tb_indicator_scan.sv
// tb_indicator_scan: directed bench for indicator_scan with DIGITS=4,
// PRESCALE=8, GUARD=2, active-low segments and anodes. Expected outputs come
// from a slot/position model of the display and are queued per cycle, then
// popped and compared one time unit after each rising edge.
module tb_indicator_scan;

  logic clk;
  logic rst;

  indicator_scan_if #(.DIGITS(4)) bus ();

  indicator_scan #(
    .DIGITS        (4),
    .PRESCALE      (8),
    .GUARD         (2),
    .SEG_ACTIVE_LOW(1'b1),
    .AN_ACTIVE_LOW (1'b1)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .disp_io(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [12:0] OFF = {4'hF, 8'hFF, 1'b0};

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [12:0] exp_q[$];

  function automatic logic [7:0] tb_glyph(input logic [3:0] n);
    case (n)
      4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
      4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
      4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
      4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
    endcase
  endfunction

  // Output after the edge that ends cycle t of a scan that began at t=0.
  function automatic logic [12:0] model(input int t, input logic [15:0] d,
                                        input logic [3:0] dp, input logic lz);
    int         slot;
    int         pos;
    logic [3:0] an;
    logic [7:0] seg;
    logic [15:0] hi;
    slot = (t / 8) % 4;
    pos  = t % 8;
    if (pos < 2) return OFF;
    an       = 4'hF;
    an[slot] = 1'b0;
    hi       = d >> (4 * slot);
    seg      = (lz && slot != 0 && hi == 16'h0) ? 8'hFF : tb_glyph(d[4*slot +: 4]);
    if (dp[slot]) seg[7] = 1'b0;
    return {an, seg, ((t % 32) == 31)};
  endfunction

  task automatic chk(input logic [12:0] e, input string tag);
    n_cmp++;
    assert ({bus.anodes, bus.segments, bus.frame} === e)
    else begin
      n_bad++;
      $error("FAIL %s: observed an=%h seg=%h frame=%b expected an=%h seg=%h frame=%b",
             tag, bus.anodes, bus.segments, bus.frame, e[12:9], e[8:1], e[0]);
    end
  endtask

  task automatic step(input logic [12:0] e, input string tag);
    logic [12:0] got_e;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got_e = exp_q.pop_front();
    chk(got_e, tag);
  endtask

  task automatic run(input int t0, input int n, input logic [15:0] d, input logic [3:0] dp,
                     input logic lz, input string tag);
    for (int i = 0; i < n; i++) step(model(t0 + i, d, dp, lz), tag);
  endtask

  initial begin
    rst        = 1'b1;
    bus.value  = '0;
    bus.dp_in  = '0;
    bus.load   = 1'b0;
    bus.lz_en  = 1'b0;
    bus.enable = 1'b1;

    // Reset state.
    step(OFF, "reset0");
    step(OFF, "reset1");

    // Release with a load on the first cycle; frame 0 still shows zeros.
    rst       = 1'b0;
    bus.value = 16'h12AF;
    bus.load  = 1'b1;
    run(0, 1, 16'h0000, 4'h0, 1'b0, "first_slot");
    bus.load = 1'b0;
    run(1, 31, 16'h0000, 4'h0, 1'b0, "frame_zero");
    run(32, 64, 16'h12AF, 4'h0, 1'b0, "scan_12AF");

    // Asynchronous reset in the middle of digit 0.
    run(96, 5, 16'h12AF, 4'h0, 1'b0, "pre_rst");
    #2 rst = 1'b1;
    #1 chk(OFF, "rst_async");
    @(posedge clk);
    #1 chk(OFF, "rst_hold");
    rst = 1'b0;

    // Leading-zero suppression with dp on the blanked top digit.
    bus.value = 16'h0030;
    bus.dp_in = 4'b1000;
    bus.lz_en = 1'b1;
    bus.load  = 1'b1;
    run(0, 1, 16'h0000, 4'h0, 1'b1, "lz_first");
    bus.load = 1'b0;
    run(1, 31, 16'h0000, 4'h0, 1'b1, "lz_zero");
    run(32, 32, 16'h0030, 4'b1000, 1'b1, "lz_on");
    bus.lz_en = 1'b0;
    run(64, 32, 16'h0030, 4'b1000, 1'b0, "lz_off");

    // Tear-free: loads mid digit 1 and mid digit 3 only show next frame.
    run(96, 12, 16'h0030, 4'b1000, 1'b0, "tear_a");
    bus.value = 16'h1111;
    bus.dp_in = 4'h0;
    bus.load  = 1'b1;
    run(108, 1, 16'h0030, 4'b1000, 1'b0, "tear_b");
    bus.load = 1'b0;
    run(109, 13, 16'h0030, 4'b1000, 1'b0, "tear_c");
    bus.value = 16'h2222;
    bus.load  = 1'b1;
    run(122, 1, 16'h0030, 4'b1000, 1'b0, "tear_d");
    bus.load = 1'b0;
    run(123, 5, 16'h0030, 4'b1000, 1'b0, "tear_e");
    run(128, 32, 16'h2222, 4'h0, 1'b0, "tear_new");

    // Load on the wrap cycle goes straight to the displayed copy.
    run(160, 31, 16'h2222, 4'h0, 1'b0, "wrapld_a");
    bus.value = 16'h5555;
    bus.load  = 1'b1;
    run(191, 1, 16'h2222, 4'h0, 1'b0, "wrapld_b");
    bus.load = 1'b0;
    run(192, 64, 16'h5555, 4'h0, 1'b0, "wrapld_new");

    // Enable low mid digit 2 for 5 cycles; a load in that window is kept.
    run(256, 20, 16'h5555, 4'h0, 1'b0, "en_pre");
    bus.enable = 1'b0;
    bus.value  = 16'h0F0F;
    bus.load   = 1'b1;
    step(OFF, "en_low");
    bus.load = 1'b0;
    for (int i = 0; i < 4; i++) step(OFF, "en_low");
    bus.enable = 1'b1;
    run(0, 32, 16'h5555, 4'h0, 1'b0, "en_resume");
    run(32, 32, 16'h0F0F, 4'h0, 1'b0, "en_pending");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/indicator_scan.md
# indicator_scan

Multiplexed N-digit hex 7-segment display driver. It holds a DIGITS-wide hex value with per-digit decimal points and time-multiplexes one shared segment bus across DIGITS anode lines. Features: programmable refresh rate, inter-digit ghosting guard, tear-free frame-synchronous updates and optional leading-zero suppression. It sits between the control/readout logic and the board LED indicators.

## Interface
- DIGITS, 4: number of digits/anodes (1..16).
- PRESCALE, 50000: clocks per digit slot (≥ GUARD+2).
- GUARD, 2: clocks at start of each slot with all anodes off (0..PRESCALE-2).
- SEG_ACTIVE_LOW, 1: 1 = segment lit by 0; 0 = lit by 1.
- AN_ACTIVE_LOW, 1: 1 = anode selected by 0; 0 = selected by 1.

- clk  in  1  system clock; the only clock.
- rst  in  1  reset, asynchronous, active-high.
- value  in  4*DIGITS  hex nibbles; value[3:0] is digit 0 (rightmost, least significant).
- dp_in  in  DIGITS  decimal point request per digit.
- load  in  1  capture value/dp_in this cycle.
- lz_en  in  1  leading-zero suppression enable.
- enable  in  1  display enable.
- segments  out  8  bit7 = dp, bits 6:0 = g..a.
- anodes  out  DIGITS  one-hot digit select.
- frame  out  1  one-cycle pulse at end of each full scan.

## Operation
- Glyphs, active-low form with dp off: 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8 8:80 9:90 A:88 b:83 C:C6 d:A1 E:86 F:8E.
- DP lit clears bit7.
- SEG_ACTIVE_LOW=0 inverts all 8 bits. AN_ACTIVE_LOW=0 inverts anodes.
- "Off" means all segments unlit / all anodes deselected in the configured polarity.
- Prescaler cnt counts 0..PRESCALE-1. tick = (cnt == PRESCALE-1).
- On tick: cnt←0 and idx←idx+1, wrapping DIGITS-1→0.
- Data registers: pending (value, dp), pend_flag, active (value, dp).
- load: pending←inputs, pend_flag←1. A later load before the wrap overwrites pending.
- Frame wrap = tick with idx == DIGITS-1.
  - On a wrap with pend_flag=1: active←pending, pend_flag←0.
  - load on the wrap cycle: inputs go straight to active, pend_flag←0.
- Leading-zero suppression (lz_en=1): digit k (k ≥ 1) is blanked if nibbles k..DIGITS-1 of active are all zero.
  - A blanked digit drives segments off, except dp if its dp bit is set.
  - Its anode still scans normally.
  - Digit 0 is never blanked.
- enable=0 forces cnt←0 and idx←0 and drives outputs off. pending/active keep their contents; load still captures.
- frame output pulses on each frame wrap while enable=1.

## Timing
- Reset values:
  - segments: off (8'hFF for SEG_ACTIVE_LOW=1).
  - anodes: off (all ones for AN_ACTIVE_LOW=1).
  - frame: 0.
  - cnt, idx, pending, active, pend_flag: 0.
- Outputs are registered, with 1-cycle latency: outputs after edge n reflect idx/cnt/active before edge n.
- Guard: anodes and segments are off whenever the sampled cnt < GUARD.
- Each slot is PRESCALE clocks long, of which PRESCALE-GUARD are active. A full frame is DIGITS·PRESCALE clocks.
- After rst deasserts with enable=1, anode 0 first asserts on the (GUARD+1)th rising edge.
- frame is registered and goes high on the edge after the wrap edge, for 1 cycle.
- New active data appears on segments in the first slot after the wrap (digit 0), after its guard.
- rst mid-operation forces reset values immediately, without waiting for clk. Scanning restarts at digit 0 on the first edge after release.
- enable falling: outputs off from the next edge.
- enable rising: restart exactly as after reset, with cnt=0, idx=0 and a guard.

## Test plan
Bench parameters: DIGITS=4, PRESCALE=8, GUARD=2, both polarities active-low.
- Reset: assert rst mid-slot -> segments=FF and anodes=F immediately, frame=0; after release, anodes=E first on the 3rd edge.
- Load 16'h12AF with dp_in=0, then run 2 frames -> slot sequence shows anodes E/8E, D/88, B/A4, 7/F9. Each slot has 6 active clocks and 2 clocks of F/FF. frame pulses every 32 clocks.
- Leading-zero suppression: load 16'h0030 with lz_en=1 and dp_in=4'b1000 -> digit0 C0, digit1 B0, digit2 FF, digit3 7F. With lz_en=0 -> digit2 C0, digit3 40.
- Tear-free update: load 16'h1111 mid digit 1, then 16'h2222 mid digit 3 -> the current frame keeps the old data; every digit of the next frame shows A4; no frame mixes values.
- Load coinciding with the wrap tick, value 16'h5555 -> the next frame shows 92 on all digits, and pend_flag is 0 afterwards.
- enable drops mid digit 2 for 5 cycles -> outputs off from the next edge; after re-enable, digit 0 resumes after the 2-clock guard, and no frame pulse occurs while enable is low.
